// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: arbitrates stalls and redirects for PC, IF/ID, ID/EX.
// Also keeps the bus-wait timeout and stall-cycle debug counters.
module pipe_ctrl #(
  parameter int DW        = 32,
  parameter int FLUSH_CYC = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          jump_req_i,
  input  logic [DW-1:0] jump_addr_i,
  input  logic          int_req_i,
  input  logic [DW-1:0] int_addr_i,
  input  logic          div_busy_i,
  input  logic          bus_wait_i,
  output logic          jump_o,
  output logic [DW-1:0] jump_addr_o,
  output logic          int_ack_o,
  output logic          hold_pc_o,
  output logic          hold_if_id_o,
  output logic          hold_id_ex_o,
  output logic          flush_if_id_o,
  output logic          flush_id_ex_o,
  output logic          bus_timeout_o,
  output logic [31:0]   stall_cnt_o
);

  localparam int CW = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYC - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [15:0]   wait_cnt;
  logic [31:0]   stall_cnt;
  logic          stall;

  assign stall = div_busy_i | bus_wait_i;

  always_comb begin
    jump_o        = 1'b0;
    jump_addr_o   = '0;
    int_ack_o     = 1'b0;
    hold_pc_o     = 1'b0;
    hold_if_id_o  = 1'b0;
    hold_id_ex_o  = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    bus_timeout_o = 1'b0;
    if (!rst) begin
      if (state == FLUSH) begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (stall) begin
        hold_pc_o     = 1'b1;
        hold_if_id_o  = 1'b1;
        hold_id_ex_o  = 1'b1;
        bus_timeout_o = bus_wait_i
                      && (wait_cnt == WAIT_LAST);
      end else if (int_req_i) begin
        jump_o        = 1'b1;
        jump_addr_o   = int_addr_i;
        int_ack_o     = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end else if (jump_req_i) begin
        jump_o        = 1'b1;
        jump_addr_o   = jump_addr_i;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
      end
    end
  end

  assign stall_cnt_o = rst ? '0 : stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        // a single bubble is covered by the redirect cycle itself
        if (jump_o && (FLUSH_CYC > 1)) begin
          state <= FLUSH;
          cnt   <= CNT_INIT;
        end
      end else begin
        cnt <= cnt - 1'b1;
        if (cnt == CNT_LAST) state <= IDLE;
      end

      if ((state == FLUSH) || !bus_wait_i
          || bus_timeout_o)
        wait_cnt <= '0;
      else
        wait_cnt <= wait_cnt + 1'b1;

      if (hold_pc_o && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: three instances (FLUSH_CYC 1/3/4) against a
// redirect/stall model, plus directed literal checks.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jr = 1'b1;
  logic [31:0] ja = 32'h100;
  logic        ir = 1'b1;
  logic [31:0] ia = 32'h80;
  logic        db = 1'b1;
  logic        bw = 1'b1;

  logic        jmp [3];
  logic [31:0] jad [3];
  logic        ack [3];
  logic        hpc [3];
  logic        hif [3];
  logic        hid [3];
  logic        fif [3];
  logic        fid [3];
  logic        tmo [3];
  logic [31:0] scnt [3];

  int checks = 0;
  int errors = 0;

  int          fl_m [3];
  int          wt_m [3];
  logic [31:0] stc_m [3];
  logic        sat_pre = 1'b0;

  always #5 clk = ~clk;

  function automatic int fc_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  function automatic int to_of(input int g);
    return (g == 2) ? 255 : 4;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipe_ctrl #(
      .DW(32),
      .FLUSH_CYC((g == 0) ? 1 : (g == 1) ? 3 : 4),
      .TIMEOUT((g == 2) ? 255 : 4)
    ) u (
      .clk(clk), .rst(rst),
      .jump_req_i(jr), .jump_addr_i(ja),
      .int_req_i(ir), .int_addr_i(ia),
      .div_busy_i(db), .bus_wait_i(bw),
      .jump_o(jmp[g]), .jump_addr_o(jad[g]),
      .int_ack_o(ack[g]), .hold_pc_o(hpc[g]),
      .hold_if_id_o(hif[g]), .hold_id_ex_o(hid[g]),
      .flush_if_id_o(fif[g]), .flush_id_ex_o(fid[g]),
      .bus_timeout_o(tmo[g]), .stall_cnt_o(scnt[g])
    );
  end

  task automatic chk(input string nm, input int inst,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h want %h",
               nm, inst, act, exp);
    end
  endtask

  // model: fl_m = remaining bubble cycles after the redirect cycle
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [31:0] cur;
      cur = (i == 2 && sat_pre) ? 32'hFFFF_FFFE
                                : stc_m[i];
      if (rst) begin
        fl_m[i]  <= 0;
        wt_m[i]  <= 0;
        stc_m[i] <= '0;
      end else if (fl_m[i] > 0) begin
        fl_m[i]  <= fl_m[i] - 1;
        wt_m[i]  <= 0;
        stc_m[i] <= cur;
      end else if (db || bw) begin
        if (bw && wt_m[i] < to_of(i) - 1)
          wt_m[i] <= wt_m[i] + 1;
        else
          wt_m[i] <= 0;
        stc_m[i] <= (cur == 32'hFFFF_FFFF) ? cur
                                           : cur + 1;
      end else begin
        wt_m[i]  <= 0;
        stc_m[i] <= cur;
        if (ir || jr) fl_m[i] <= fc_of(i) - 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      logic [7:0]  ec;
      logic [31:0] ea;
      ec = '0;
      ea = '0;
      if (!rst) begin
        if (fl_m[i] > 0)
          ec = 8'b0000_0110;
        else if (db || bw)
          ec = {5'b00111, 2'b00,
                bw && (wt_m[i] == to_of(i) - 1)};
        else if (ir) begin
          ec = 8'b1100_0110;
          ea = ia;
        end else if (jr) begin
          ec = 8'b1000_0110;
          ea = ja;
        end
      end
      chk("ctl", i,
          {24'd0, jmp[i], ack[i], hpc[i], hif[i],
           hid[i], fif[i], fid[i], tmo[i]}, {24'd0, ec});
      chk("addr", i, jad[i], ea);
      chk("stall_cnt", i, scnt[i],
          rst ? 32'd0 : stc_m[i]);
    end
  end

  task automatic apply(input logic r, input logic j,
                       input logic [31:0] jad_v,
                       input logic i_r,
                       input logic [31:0] iad_v,
                       input logic d, input logic b);
    @(posedge clk);
    #1;
    sat_pre = 1'b0;
    rst = r; jr = j; ja = jad_v;
    ir = i_r; ia = iad_v; db = d; bw = b;
    @(negedge clk);
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int k = 0; k < n; k++)
      apply(0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int nf, nt, nh;
    logic [31:0] s0;

    // T1 reset with every input high
    for (int k = 0; k < 3; k++) begin
      apply(1, 1, 32'h100, 1, 32'h80, 1, 1);
      chk("rst_jump", 0, {31'd0, jmp[0]}, 0);
      chk("rst_hold", 0, {31'd0, hpc[0]}, 0);
    end
    idle_n(1);
    chk("rst_scnt", 0, scnt[0], 0);

    // T2 jump
    nf = 0;
    apply(0, 1, 32'h100, 0, 0, 0, 0);
    chk("t2_jump", 0, {31'd0, jmp[0]}, 1);
    chk("t2_addr", 0, jad[0], 32'h100);
    chk("t2_flush", 0, {30'd0, fif[0], fid[0]}, 3);
    nf += int'(fif[1]);
    for (int k = 0; k < 4; k++) begin
      apply(0, 0, 0, 0, 0, 0, 0);
      if (k == 0)
        chk("t2_after", 0,
            {29'd0, jmp[0], fif[0], fid[0]}, 0);
      nf += int'(fif[1]);
    end
    chk("t2_fc3_len", 1, nf, 3);

    // T3 priority then deferral under div_busy
    apply(0, 1, 32'h100, 1, 32'h80, 0, 0);
    chk("t3_addr", 0, jad[0], 32'h80);
    chk("t3_ack", 0, {31'd0, ack[0]}, 1);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("t3_ack_once", 0, {31'd0, ack[0]}, 0);
    idle_n(4);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 32'h100, 1, 32'h80, 1, 0);
      chk("t3_hold", 0,
          {29'd0, hpc[0], hif[0], hid[0]}, 7);
      chk("t3_nojump", 0, {30'd0, jmp[0], ack[0]}, 0);
    end
    apply(0, 1, 32'h100, 1, 32'h80, 0, 0);
    chk("t3_late_ack", 0, {30'd0, jmp[0], ack[0]}, 3);
    idle_n(4);

    // T4 bus-wait timeout, TIMEOUT=4
    s0 = scnt[0];
    nt = 0;
    nh = 0;
    for (int k = 1; k <= 10; k++) begin
      apply(0, 0, 0, 0, 0, 0, 1);
      chk("t4_tmo", 0, {31'd0, tmo[0]},
          (k == 4 || k == 8) ? 32'd1 : 32'd0);
      nt += int'(tmo[0]);
      nh += int'(hpc[0]);
    end
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("t4_pulses", 0, nt, 2);
    chk("t4_holds", 0, nh, 10);
    chk("t4_scnt", 0, scnt[0] - s0, 10);

    // T5 reset during a FLUSH_CYC=4 redirect
    apply(0, 1, 32'h200, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("t5_inflush", 2, {30'd0, fif[2], fid[2]}, 3);
    apply(1, 0, 0, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("t5_clear", 2,
        {27'd0, fif[2], fid[2], hpc[2], jmp[2], ack[2]},
        0);
    chk("t5_scnt", 2, scnt[2], 0);

    // T6 stall counter saturation
    idle_n(1);
    force g_dut[2].u.stall_cnt = 32'hFFFF_FFFE;
    sat_pre = 1'b1;
    #1;
    release g_dut[2].u.stall_cnt;
    for (int k = 0; k < 3; k++)
      apply(0, 0, 0, 0, 0, 1, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    chk("t6_sat", 2, scnt[2], 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
